mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers. It extends the pipelined MIPS datapath with MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the ALU in the EX stage. The hazard logic stalls on BUSY; MFHI/MFLO read HI/LO directly.
- Operand width is parametrised. Operations run as a multi-cycle FSM with a start/busy/done handshake and flush support.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal values are WIDTH >= 4.

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request; sampled only when BUSY=0
- OP  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- A  in  WIDTH  operand A (multiplicand/dividend/move source)
- B  in  WIDTH  operand B (multiplier/divisor)
- FLUSH  in  1  abort in-flight operation (branch squash)
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse; HI/LO hold the new result in that cycle
- HI  out  WIDTH  high product / remainder
- LO  out  WIDTH  low product / quotient
- DIVZERO  out  1  set with DONE when the divisor was 0; held until the next accepted START

Behaviour:
- Reset: HI=0, LO=0, BUSY=0, DONE=0, DIVZERO=0, state IDLE, iteration counter 0. RESET has priority over everything, including mid-operation; HI/LO are cleared.
- States: IDLE, CALC, FIX, FIN.
  - BUSY=1 in CALC and FIX only.
  - DONE is a registered output, 1 only in FIN.
- START acceptance:
  - START is accepted in IDLE or FIN. In FIN this gives back-to-back operations.
  - START while BUSY=1 is ignored; there is no queueing.
- Accepted START with OP=MTHI or MTLO: HI or LO := A at that edge. State goes to IDLE, no DONE, BUSY stays 0.
- Accepted START with OP=11x: no effect.
- Accepted START with a mul/div OP:
  - Edge 0: latch operands. For signed ops, latch absolute values plus the result signs. The quotient sign is sign(A)^sign(B); the remainder sign is sign(A).
  - Clear DIVZERO. Load counter = WIDTH and go to CALC.
- CALC: one radix-2 step per edge. Counter decrements; at 0 go to FIX. CALC lasts exactly WIDTH edges.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division producing a WIDTH-bit quotient and WIDTH-bit remainder.
- FIX: one edge. It applies two's-complement sign correction, writes HI/LO, and goes to FIN.
- FIN: DONE=1 for one cycle, then IDLE (unless START is accepted).
- Latency: START sampled at edge 0, DONE high after edge WIDTH+1, so WIDTH+2 cycles start-to-done. HI/LO are updated only at the FIX edge and are stable otherwise.
- Multiply results: full 2*WIDTH product; HI = upper half, LO = lower half. MULT is signed, MULTU is unsigned.
- Divide by zero (B=0, DIV or DIVU):
  - Normal latency. LO = all ones, HI = A (original, unsigned bit pattern), DIVZERO=1 with DONE.
  - No sign correction is applied.
- Signed overflow (DIV, A = most negative, B = all ones): LO = most negative, HI = 0, no flag.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- FLUSH:
  - In CALC or FIX: return to IDLE next edge, HI/LO unchanged, no DONE. FLUSH and START in the same cycle: FLUSH wins, START dropped.
  - In IDLE or FIN: no effect on HI/LO. A START sampled in that cycle is dropped.
- Counter width is clog2(WIDTH)+1. No wrap-around occurs because the counter is loaded only on an accepted START.

Test Plan:
- WIDTH=32, RESET 2 cycles, then MULTU A=FFFFFFFF B=FFFFFFFF -> BUSY high 33 cycles, DONE pulse in cycle 34, HI=FFFFFFFE LO=00000001; after reset HI=LO=0.
- MULT A=FFFFFFFD(-3) B=00000005 -> HI=FFFFFFFF LO=FFFFFFF1. Then DIV A=FFFFFFF9(-7) B=00000002 -> LO=FFFFFFFD HI=FFFFFFFF.
- Divide boundaries:
  - DIVU A=00000007 B=0 -> LO=FFFFFFFF HI=00000007 DIVZERO=1.
  - Next START clears DIVZERO.
  - DIV A=80000000 B=FFFFFFFF -> LO=80000000 HI=00000000, DIVZERO=0.
- Handshake:
  - START MULTU 3*4, then re-pulse START (OP=DIVU 1/1) at cycle 10 -> ignored; result HI=0 LO=0000000C.
  - START asserted in the FIN cycle -> accepted; DONE again WIDTH+2 cycles later.
- Flush and reset:
  - MTHI A=AAAA0000, MTLO A=5555 -> HI/LO updated the next cycle, no DONE.
  - Then MULTU with FLUSH at cycle 15 -> BUSY drops, HI/LO keep AAAA0000/00005555, no DONE.
  - RESET mid-CALC -> all outputs 0.
- WIDTH=8 instance: MULT 0x80*0x80 -> HI=0x40 LO=0x00 after 10 cycles. DIVU 0xFF/0x10 -> LO=0x0F HI=0x0F.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider with HI/LO result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DIVZERO
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0] opa, opb, abs_a, abs_b, q_fix, r_fix, a_back;
    logic [WIDTH:0] msum, rsh, rdiff;
    logic is_div, neg_q, neg_r, accept, sa, sb, dz;
    assign accept = START && !FLUSH && (state == IDLE || state == FIN);
    assign sa = !OP[0] && A[WIDTH-1];
    assign sb = !OP[0] && B[WIDTH-1];
    assign abs_a = sa ? -A : A;
    assign abs_b = sb ? -B : B;
    assign BUSY = state == CALC || state == FIX;
    assign DONE = state == FIN;
    // Multiply keeps the multiplier in the low half; divide keeps the partial remainder in the high half
    assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
    assign rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rdiff = rsh - {1'b0, opb};
    assign prod = neg_q ? -acc : acc;
    assign q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // Re-signing the latched magnitude recovers the original dividend for the divide-by-zero HI value
    assign a_back = neg_r ? -opa : opa;
    assign dz = opb == '0;
    always_comb begin
        state_n = state;
        if (FLUSH && BUSY)
            state_n = IDLE;
        else if (accept)
            state_n = OP[2] ? IDLE : CALC;
        else if (state == CALC)
            state_n = (cnt == CW'(1)) ? FIX : CALC;
        else if (state == FIX)
            state_n = FIN;
        else if (state == FIN)
            state_n = IDLE;
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opa <= '0;
            opb <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            HI <= '0;
            LO <= '0;
            DIVZERO <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                DIVZERO <= 1'b0;
                if (OP == 3'b100)
                    HI <= A;
                if (OP == 3'b101)
                    LO <= A;
                if (!OP[2]) begin
                    opa <= abs_a;
                    opb <= abs_b;
                    is_div <= OP[1];
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    cnt <= CW'(WIDTH);
                    acc <= {{WIDTH{1'b0}}, OP[1] ? abs_a : abs_b};
                end
            end else if (state == CALC && !FLUSH) begin
                cnt <= cnt - CW'(1);
                acc <= is_div ? {rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0], acc[WIDTH-2:0], !rdiff[WIDTH]}
                              : {msum, acc[WIDTH-1:1]};
            end else if (state == FIX && !FLUSH) begin
                HI <= is_div ? (dz ? a_back : r_fix) : prod[2*WIDTH-1:WIDTH];
                LO <= is_div ? (dz ? '1 : q_fix) : prod[WIDTH-1:0];
                DIVZERO <= is_div && dz;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst, start, flush;
    logic [2:0] op;
    logic [31:0] a, b;
    logic busy, done, divzero;
    logic [31:0] hi, lo;
    logic start8;
    logic [2:0] op8;
    logic [7:0] a8, b8, hi8, lo8;
    logic busy8, done8, divzero8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .CLOCK(clk), .RESET(rst), .START(start), .OP(op), .A(a), .B(b), .FLUSH(flush),
        .BUSY(busy), .DONE(done), .HI(hi), .LO(lo), .DIVZERO(divzero)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .CLOCK(clk), .RESET(rst), .START(start8), .OP(op8), .A(a8), .B(b8), .FLUSH(1'b0),
        .BUSY(busy8), .DONE(done8), .HI(hi8), .LO(lo8), .DIVZERO(divzero8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {divzero, hi, lo} from plain signed/unsigned arithmetic
    function automatic logic [64:0] model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint sa = longint'($signed(ma));
        longint sb = longint'($signed(mb));
        longint unsigned ua = {32'd0, ma};
        longint unsigned ub = {32'd0, mb};
        logic [63:0] p;
        if (mop[1] && mb == 32'd0)
            return {1'b1, ma, 32'hFFFF_FFFF};
        case (mop)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: p = {32'(sa % sb), 32'(sa / sb)};
            3'd3: p = {32'(ua % ub), 32'(ua / ub)};
            default: p = '0;
        endcase
        return {1'b0, p};
    endfunction

    task automatic wait_done(output int k, output int nbusy);
        k = 0;
        nbusy = busy ? 1 : 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (busy)
                nbusy++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit b2b);
        int k, nb;
        logic [64:0] e;
        e = model(o, x, y);
        if (!b2b)
            @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, nb);
        chk({tag, "_lat"}, k, 33);
        chk({tag, "_busy"}, nb, 33);
        chk({tag, "_hilo"}, {hi, lo}, e[63:0]);
        chk({tag, "_dz"}, divzero, e[64]);
    endtask

    initial begin
        int k, nb, nd;
        logic [31:0] x, y;
        logic [2:0] o;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_out", {hi, lo, busy, done, divzero}, '0);

        do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        chk("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_zero", 3'd3, 32'd7, 32'd0, 0);
        chk("divu_zero_val", {divzero, hi, lo}, {1'b1, 64'h0000_0007_FFFF_FFFF});
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_val", {divzero, hi, lo}, {1'b0, 64'h0000_0000_8000_0000});
        do_op("div_zero_s", 3'd2, 32'hFFFF_FFF0, 32'd0, 0);

        // A START while busy must be ignored and not queued
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, nb);
        chk("ignore_lat", 9 + k, 33);
        chk("ignore_val", {hi, lo}, 64'h0000_0000_0000_000C);
        @(negedge clk);
        chk("ignore_idle", {busy, done}, 2'b00);

        do_op("b2b_first", 3'd0, 32'h1234_5678, 32'hFEDC_BA98, 0);
        do_op("b2b_second", 3'd2, 32'h8765_4321, 32'h0000_1234, 1);

        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = (i % 5 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op($sformatf("rand%0d", i), o, x, y, i % 4 == 1);
        end

        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
        @(negedge clk);
        chk("mthi", {hi, busy, done}, {32'hAAAA_0000, 2'b00});
        op = 3'd5; a = 32'h0000_5555;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo", {hi, lo, busy, done}, {64'hAAAA_0000_0000_5555, 2'b00});
        op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nop", {hi, lo, busy, done}, {64'hAAAA_0000_0000_5555, 2'b00});

        // Flush mid-multiply with a competing START
        start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_state", {busy, done, hi, lo}, {2'b00, 64'hAAAA_0000_0000_5555});
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy)
                nd++;
        end
        chk("flush_quiet", nd, 0);
        chk("flush_hold", {hi, lo}, 64'hAAAA_0000_0000_5555);

        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_mid", {hi, lo, busy, done, divzero}, '0);
        repeat (40) @(negedge clk);
        chk("reset_mid_quiet", {hi, lo, busy, done}, '0);

        start8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("w8_mult_lat", k, 9);
        chk("w8_mult_val", {hi8, lo8}, 16'h4000);
        @(negedge clk);
        start8 = 1'b1; op8 = 3'd3; a8 = 8'hFF; b8 = 8'h10;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("w8_divu_lat", k, 9);
        chk("w8_divu_val", {divzero8, hi8, lo8}, {1'b0, 16'h0F0F});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
